// File: rtl/game_pkg.sv
// Shared game definitions: top-level state codes, button bit positions,
// router FSM states, and small decode helpers used by button_router.
package game_pkg;

  localparam logic [3:0] ST_MENU        = 4'b0000;
  localparam logic [3:0] ST_VOL         = 4'b0001;
  localparam logic [3:0] ST_POKE        = 4'b0010;
  localparam logic [3:0] ST_POKE_OVER   = 4'b0011;
  localparam logic [3:0] ST_FRUIT       = 4'b0100;
  localparam logic [3:0] ST_POTION      = 4'b0101;
  localparam logic [3:0] ST_POTION_INIT = 4'b0110;
  localparam logic [3:0] ST_POTION_OVER = 4'b0111;
  localparam logic [3:0] ST_POTION_WIN  = 4'b1000;
  localparam logic [3:0] ST_FRUIT_OVER  = 4'b1001;

  // Bit positions in the {C,U,D,L,R} button bus; a higher index wins priority.
  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_C = 4;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    BLANK   = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } router_fsm_e;

  typedef enum logic [2:0] {
    DST_NONE   = 3'd0,
    DST_MENU   = 3'd1,
    DST_VOL    = 3'd2,
    DST_POKE   = 3'd3,
    DST_FRUIT  = 3'd4,
    DST_POTION = 3'd5,
    DST_PAGE   = 3'd6
  } route_e;

  function automatic route_e route_of(input logic [3:0] st);
    route_e r;
    case (st)
      ST_MENU:        r = DST_MENU;
      ST_VOL:         r = DST_VOL;
      ST_POKE:        r = DST_POKE;
      ST_FRUIT:       r = DST_FRUIT;
      ST_POTION:      r = DST_POTION;
      ST_POKE_OVER,
      ST_POTION_OVER,
      ST_POTION_WIN,
      ST_FRUIT_OVER:  r = DST_PAGE;
      ST_POTION_INIT: r = DST_NONE;
      default:        r = DST_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_priority_pick.sv
// Combinational priority select over the 5-bit button bus (C > U > D > L > R):
// returns the single winning bit and the mask of bits that lost.
module btn_priority_pick
  import game_pkg::*;
(
  input  logic [4:0] req,
  output logic [4:0] grant,
  output logic [4:0] losers
);

  genvar gi;
  generate
    for (gi = BTN_R; gi <= BTN_C; gi = gi + 1) begin : g_pick
      if (gi == BTN_C) begin : g_top
        assign grant[gi] = req[gi];
      end else begin : g_low
        assign grant[gi] = req[gi] & ~(|req[BTN_C:gi+1]);
      end
    end
  endgenerate

  assign losers = req & ~grant;

endmodule

// File: rtl/button_router.sv
// Routes single-pulse button presses to the consumer selected by `state`, with
// input blanking after state changes and optional hold-off. Optional macro
// BUTTON_ROUTER_DROP_CNT_EN adds a saturating dropped-press counter (drop_cnt).
module button_router
  import game_pkg::*;
#(
  parameter int BLANK_CYCLES = 200,
  parameter int GAP_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_in,
  input  logic [3:0] state,
  output logic [4:0] btn_menu,
  output logic [4:0] btn_vol,
  output logic [4:0] btn_poke,
  output logic [4:0] btn_fruit,
  output logic [4:0] btn_potion,
  output logic [4:0] btn_page,
`ifdef BUTTON_ROUTER_DROP_CNT_EN
  output logic [7:0] drop_cnt,
`endif
  output logic       input_blank
);

  generate
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > 1023) begin : g_bad_blank
      $error("button_router: BLANK_CYCLES must be in 1..1023");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 1023) begin : g_bad_gap
      $error("button_router: GAP_CYCLES must be in 0..1023");
    end
  endgenerate

  // The change cycle is itself the first blanked cycle, so a change reloads one
  // less than reset does; with a one-cycle blank the change cycle is all of it.
  localparam bit               CHG_TO_BLANK = (BLANK_CYCLES > 1);
  localparam bit               GAP_EN       = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHG_RELOAD   = CHG_TO_BLANK ? CNT_W'(BLANK_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] GAP_RELOAD   = GAP_EN ? CNT_W'(GAP_CYCLES - 1) : '0;

  router_fsm_e      fsm_reg, fsm_next;
  logic [CNT_W-1:0] blank_cnt_reg, blank_cnt_next;
  logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [3:0]       state_q;
  logic             chg;
  logic             blank_now;
  logic             fwd;
  logic [4:0]       grant;
  logic [4:0]       pick_losers;
  route_e           dest;

  btn_priority_pick u_pick (
    .req    (btn_in),
    .grant  (grant),
    .losers (pick_losers)
  );

  assign chg       = (state != state_q);
  assign dest      = route_of(state);
  assign blank_now = chg || (fsm_reg == BLANK);

  always_comb begin
    fsm_next       = fsm_reg;
    blank_cnt_next = blank_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    fwd            = 1'b0;
    if (chg) begin
      fsm_next       = CHG_TO_BLANK ? BLANK : ACTIVE;
      blank_cnt_next = CHG_RELOAD;
    end else begin
      case (fsm_reg)
        BLANK: begin
          if (blank_cnt_reg == '0) begin
            fsm_next = ACTIVE;
          end else begin
            blank_cnt_next = blank_cnt_reg - CNT_W'(1);
          end
        end
        ACTIVE: begin
          if ((|grant) && (dest != DST_NONE)) begin
            fwd = 1'b1;
            if (GAP_EN) begin
              fsm_next     = HOLDOFF;
              gap_cnt_next = GAP_RELOAD;
            end
          end
        end
        HOLDOFF: begin
          if (gap_cnt_reg == '0) begin
            fsm_next = ACTIVE;
          end else begin
            gap_cnt_next = gap_cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          fsm_next       = BLANK;
          blank_cnt_next = BLANK_RELOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= BLANK;
      blank_cnt_reg <= BLANK_RELOAD;
      gap_cnt_reg   <= '0;
      state_q       <= ST_MENU;
    end else begin
      fsm_reg       <= fsm_next;
      blank_cnt_reg <= blank_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      state_q       <= state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_menu    <= '0;
      btn_vol     <= '0;
      btn_poke    <= '0;
      btn_fruit   <= '0;
      btn_potion  <= '0;
      btn_page    <= '0;
      input_blank <= 1'b1;
    end else begin
      btn_menu    <= (fwd && dest == DST_MENU)   ? grant : 5'b0;
      btn_vol     <= (fwd && dest == DST_VOL)    ? grant : 5'b0;
      btn_poke    <= (fwd && dest == DST_POKE)   ? grant : 5'b0;
      btn_fruit   <= (fwd && dest == DST_FRUIT)  ? grant : 5'b0;
      btn_potion  <= (fwd && dest == DST_POTION) ? grant : 5'b0;
      btn_page    <= (fwd && dest == DST_PAGE)   ? grant : 5'b0;
      input_blank <= blank_now;
    end
  end

`ifdef BUTTON_ROUTER_DROP_CNT_EN
  // A forwarded cycle drops only the priority losers; any other cycle drops all.
  logic [2:0] drop_inc;
  logic [8:0] drop_sum;

  assign drop_inc = fwd ? popcount5(pick_losers) : popcount5(btn_in);
  assign drop_sum = {1'b0, drop_cnt} + {6'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (chg) begin
      drop_cnt <= '0;
    end else if (drop_sum[8]) begin
      drop_cnt <= 8'hFF;
    end else begin
      drop_cnt <= drop_sum[7:0];
    end
  end
`else
  logic unused_losers;
  assign unused_losers = ^pick_losers;
`endif

endmodule
